id_hazard_scoreboard: RTL and testbench
=======================================

# id_hazard_scoreboard

Decode-stage RAW hazard detector for the 16-bit WISC pipeline. It sits directly upstream of `rf_bypass` in the ID stage and tracks destination registers of instructions in flight between decode and writeback. It stalls decode while a source register has an older pending write that the register-file bypass cannot yet supply. The writeback-cycle case is covered by `rf_bypass` write-through, so it never causes a stall.

## Interface
- `DEPTH`, default 2: number of tracked in-flight stages between ID and WB (EX, MEM).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `id_valid` input 1: a valid instruction is in decode this cycle.
- `read1regsel` input 3: source register 1, the same value driven to `rf_bypass`.
- `read2regsel` input 3: source register 2.
- `rd1_en` input 1: the instruction actually reads source 1.
- `rd2_en` input 1: the instruction actually reads source 2.
- `dst_sel` input 3: destination register of the decoding instruction.
- `dst_we` input 1: the decoding instruction writes `dst_sel`.
- `flush` input 1: kill decode and all tracked in-flight entries (branch redirect).
- `stall` output 1: hold PC and IF/ID; inject a bubble into EX.
- `busy_mask` output 8: bit r is 1 when any valid entry targets register r.
- `stall_cnt` output 16: saturating stall-cycle counter; see Configuration.

## Operation
- State: entries `e[0..DEPTH-1]`, each {valid, reg[2:0]}. `e[0]` is the instruction in EX and `e[DEPTH-1]` is the oldest before WB.
- `match(s)` = OR over i of (`e[i].valid` & `e[i].reg == s`).
- `stall` = `id_valid` & ~`flush` & ((`rd1_en` & match(`read1regsel`)) | (`rd2_en` & match(`read2regsel`))). This is combinational from inputs and state.
- `accept` = `id_valid` & ~`stall` & ~`flush`.
- Each cycle:
  - shift `e[i+1] <= e[i]`;
  - `e[0] <= {accept & dst_we, dst_sel}`.
  - A stall inserts a bubble (valid=0), never a duplicate entry.
- The entry leaving `e[DEPTH-1]` is in WB and is dropped; `rf_bypass` forwards its data.
- Flush has priority over all else. On the next edge every `e[i].valid` is 0, and the decoding instruction is not recorded.
- Register 0 is an ordinary register; there is no hardwired-zero exemption.
- Self-dependency (source equals the decoding instruction's own `dst_sel`) never stalls, because only older entries are compared.
- A reg with `rd*_en`=0 never stalls, even on a match.
- `busy_mask` is derived combinationally from the entries.

## Timing
- Reset (`rst`=0): all entries invalid immediately (asynchronous). `busy_mask`=0, `stall_cnt`=0. `stall`=0 regardless of inputs because no entry is valid. Reset asserted mid-stall ends the stall in the same cycle.
- Back-to-back RAW with DEPTH=2: writer accepted at cycle t, dependent in decode at t+1. `stall`=1 in t+1 and t+2; the dependent is accepted at t+3, when the writer is in WB.
- Distance-2 dependent (one unrelated instruction between): one stall cycle. Distance 3 or more: no stall.
- Stall-to-accept has no extra latency; `stall` drops in the cycle the last matching entry leaves `e[DEPTH-1]`.

## Configuration
- `ID_HAZARD_STATS_EN` defined:
  - `stall_cnt` increments by 1 on every edge where `stall`=1.
  - It saturates at 16'hFFFF and clears only on reset.
- `ID_HAZARD_STATS_EN` not defined:
  - the port remains and is tied to 16'h0000;
  - no counter flops are synthesized.

## Structure
- Shared package `wisc_pkg`: `REG_SEL_W`=3, `NUM_REGS`=8, `HAZ_DEPTH`=2, and the entry typedef {valid, reg}.
- One sub-module `sb_stage`: a single entry flop pair (valid, reg) with async active-low reset and synchronous clear, instantiated DEPTH times in a chain.
- The comparators, `busy_mask` decode and counter live in the top level.

## Test plan
- Reset mid-stall: set `e` holding r3 so `stall`=1, then drive `rst`=0 -> `stall`=0 and `busy_mask`=8'h00 in the same cycle; `stall_cnt`=0.
- Issue r3 (`dst_we`=1) at t, then read1=r3 (`rd1_en`=1) at t+1 -> `stall`=1 at t+1 and t+2, 0 at t+3; `busy_mask`=8'h08 at t+1 and t+2.
- Issue r5 with `dst_we`=0, then read r5 -> `stall`=0; `busy_mask`=8'h00.
- Pending write to r2, read2=r2 with `rd2_en`=0 -> `stall`=0; same with `rd2_en`=1 -> `stall`=1.
- Pending r1 and r6, `flush`=1 during a stall -> `stall`=0 that cycle; next cycle `busy_mask`=0 and the flushed decode is not recorded.
- With `ID_HAZARD_STATS_EN`: one RAW pair -> `stall_cnt`=2. Preload near saturation so the count reaches 16'hFFFF, then apply further stalls -> stays 16'hFFFF. Without the macro -> `stall_cnt`=0 throughout.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: register-select geometry, hazard depth and
// the in-flight destination entry type used by the decode hazard scoreboard.
package wisc_pkg;

  localparam int REG_SEL_W   = 3;
  localparam int NUM_REGS    = 8;
  localparam int HAZ_DEPTH   = 2;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [REG_SEL_W-1:0] regsel;
  } sb_entry_t;

endpackage : wisc_pkg

// File: rtl/sb_stage.sv
// One tracked in-flight pipeline stage: a {valid, reg} flop pair with
// asynchronous active-low reset and a synchronous clear for redirects.
module sb_stage
  import wisc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear_i,
  input  sb_entry_t entry_i,
  output sb_entry_t entry_o
);

  // NOTE: sequential state uses non-blocking assignments so every stage in the
  // chain samples its neighbour's pre-edge value and the shift is order-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_o <= '0;
    end else if (clear_i) begin
      entry_o <= '0;
    end else begin
      entry_o <= entry_i;
    end
  end

endmodule : sb_stage

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: stalls ID while a source register has an
// older write still in EX..MEM. Optional stall counter under ID_HAZARD_STATS_EN.
module id_hazard_scoreboard
  import wisc_pkg::*;
#(
  parameter int DEPTH = HAZ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_SEL_W-1:0]   read1regsel,
  input  logic [REG_SEL_W-1:0]   read2regsel,
  input  logic                   rd1_en,
  input  logic                   rd2_en,
  input  logic [REG_SEL_W-1:0]   dst_sel,
  input  logic                   dst_we,
  input  logic                   flush,
  output logic                   stall,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  sb_entry_t e_q [DEPTH];
  sb_entry_t e_d [DEPTH];
  logic      match1;
  logic      match2;
  logic      accept;

  // Only older entries are compared, so an instruction never waits on itself.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    match1    = 1'b0;
    match2    = 1'b0;
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_q[i].valid) begin
        busy_mask[e_q[i].regsel] = 1'b1;
        if (e_q[i].regsel == read1regsel) match1 = 1'b1;
        if (e_q[i].regsel == read2regsel) match2 = 1'b1;
      end
    end
  end

  assign stall  = id_valid & ~flush & ((rd1_en & match1) | (rd2_en & match2));
  assign accept = id_valid & ~stall & ~flush;

  // A stalled decode enters EX as a bubble rather than a duplicate entry.
  always_comb begin
    e_d[0].valid  = accept & dst_we;
    e_d[0].regsel = dst_sel;
    for (int i = 1; i < DEPTH; i++) begin
      e_d[i] = e_q[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    sb_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .entry_i (e_d[g]),
      .entry_o (e_q[g])
    );
  end

`ifdef ID_HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule : id_hazard_scoreboard

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard: per-cycle expected {stall, busy_mask}
// go into a scoreboard queue and are compared at the following falling edge.
module tb_id_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  read1regsel;
  logic [2:0]  read2regsel;
  logic        rd1_en;
  logic        rd2_en;
  logic [2:0]  dst_sel;
  logic        dst_we;
  logic        flush;
  logic        stall;
  logic [7:0]  busy_mask;
  logic [15:0] stall_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'h0;

  logic [8:0]  exp_q [$];
  string       name_q [$];

  id_hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .read1regsel (read1regsel),
    .read2regsel (read2regsel),
    .rd1_en      (rd1_en),
    .rd2_en      (rd2_en),
    .dst_sel     (dst_sel),
    .dst_we      (dst_we),
    .flush       (flush),
    .stall       (stall),
    .busy_mask   (busy_mask),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if ({stall, busy_mask} !== e) begin
        n_fail++;
        $display("FAIL %s: got stall=%0b busy_mask=%02h, expected stall=%0b busy_mask=%02h",
                 nm, stall, busy_mask, e[8], e[7:0]);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [2:0] r1, input logic e1,
                     input logic [2:0] r2, input logic e2, input logic [2:0] dst,
                     input logic we, input logic fl, input logic exp_stall,
                     input logic [7:0] exp_mask, input string nm);
    @(posedge clk);
    #1;
    id_valid    = iv;
    read1regsel = r1;
    rd1_en      = e1;
    read2regsel = r2;
    rd2_en      = e2;
    dst_sel     = dst;
    dst_we      = we;
    flush       = fl;
    exp_q.push_back({exp_stall, exp_mask});
    name_q.push_back(nm);
    if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; read1regsel = 3'd0; read2regsel = 3'd0; rd1_en = 1'b0;
    rd2_en = 1'b0; dst_sel = 3'd0; dst_we = 1'b0; flush = 1'b0;
  endtask

  // Empties the tracked stages with flushed idle cycles and lets the monitor catch up.
  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      set_idle();
      flush = 1'b1;
    end
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cnt(input string nm);
    logic [15:0] want;
`ifdef ID_HAZARD_STATS_EN
    want = exp_cnt;
`else
    want = 16'h0000;
`endif
    n_checks++;
    if (stall_cnt !== want) begin
      n_fail++;
      $display("FAIL %s: got stall_cnt=%04h, expected %04h", nm, stall_cnt, want);
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    #3;
    id_valid = 1'b1; read1regsel = 3'd3; rd1_en = 1'b1; read2regsel = 3'd0; rd2_en = 1'b1;
    #20;
    n_checks++;
    if (stall !== 1'b0 || busy_mask !== 8'h00 || stall_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: got stall=%0b busy_mask=%02h stall_cnt=%04h, expected 0/00/0000",
               stall, busy_mask, stall_cnt);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_cnt = 16'h0;
    cyc(1, 3'd3, 1, 3'd0, 1, 3'd0, 0, 0, 0, 8'h00, "post_reset_idle");
    drain();
  endtask

  task automatic test_raw_back_to_back();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 8'h00, "raw_writer");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd4, 0, 0, 1, 8'h08, "raw_t1");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd4, 0, 0, 1, 8'h08, "raw_t2");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd4, 0, 0, 0, 8'h00, "raw_t3_accept");
    cyc(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 8'h00, "raw_after");
    drain();
    check_cnt("stall_cnt_raw_pair");
  endtask

  task automatic test_no_write();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd5, 0, 0, 0, 8'h00, "nowrite_issue");
    cyc(1, 3'd5, 1, 3'd5, 1, 3'd0, 0, 0, 0, 8'h00, "nowrite_read");
    drain();
  endtask

  task automatic test_rd_en();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0, 8'h00, "rden_writer");
    cyc(1, 3'd0, 1, 3'd2, 0, 3'd0, 0, 0, 0, 8'h04, "rden_disabled");
    cyc(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 1, 8'h04, "rden_enabled");
    cyc(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 8'h00, "rden_released");
    drain();
  endtask

  task automatic test_distance();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, 8'h00, "dist2_writer_r0");
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd7, 0, 0, 0, 8'h01, "dist2_filler");
    cyc(1, 3'd0, 1, 3'd1, 0, 3'd0, 0, 0, 1, 8'h01, "dist2_stall");
    cyc(1, 3'd0, 1, 3'd1, 0, 3'd0, 0, 0, 0, 8'h00, "dist2_accept");
    drain();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0, 8'h00, "dist3_writer");
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd7, 0, 0, 0, 8'h10, "dist3_fill1");
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd7, 0, 0, 0, 8'h10, "dist3_fill2");
    cyc(1, 3'd0, 0, 3'd4, 1, 3'd0, 0, 0, 0, 8'h00, "dist3_read");
    drain();
  endtask

  task automatic test_self_dep();
    cyc(1, 3'd6, 1, 3'd0, 0, 3'd6, 1, 0, 0, 8'h00, "selfdep_empty");
    cyc(1, 3'd2, 1, 3'd2, 1, 3'd2, 1, 0, 0, 8'h40, "selfdep_busy");
    cyc(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 8'h44, "selfdep_both");
    cyc(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 8'h04, "selfdep_r2_left");
    cyc(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 8'h00, "selfdep_empty_again");
    drain();
  endtask

  task automatic test_flush();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 8'h00, "flush_w_r1");
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0, 0, 8'h02, "flush_w_r6");
    cyc(1, 3'd1, 1, 3'd6, 1, 3'd5, 1, 0, 1, 8'h42, "flush_pre_stall");
    cyc(1, 3'd1, 1, 3'd6, 1, 3'd5, 1, 1, 0, 8'h40, "flush_kills_stall");
    cyc(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 8'h00, "flush_cleared");
    cyc(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 8'h00, "flush_not_recorded");
    drain();
  endtask

  task automatic test_back_to_back();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 8'h00, "chain_w0");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 0, 1, 8'h08, "chain_d1_s1");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 0, 1, 8'h08, "chain_d1_s2");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 0, 0, 8'h00, "chain_d1_go");
    cyc(1, 3'd0, 0, 3'd3, 1, 3'd1, 0, 0, 1, 8'h08, "chain_d2_s1");
    cyc(1, 3'd0, 0, 3'd3, 1, 3'd1, 0, 0, 1, 8'h08, "chain_d2_s2");
    cyc(1, 3'd0, 0, 3'd3, 1, 3'd1, 0, 0, 0, 8'h00, "chain_d2_go");
    drain();
    check_cnt("stall_cnt_accumulated");
  endtask

  task automatic test_reset_mid_stall();
    cyc(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 8'h00, "rststall_writer");
    cyc(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 1, 8'h08, "rststall_stalling");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || busy_mask !== 8'h00 || stall_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got stall=%0b busy_mask=%02h stall_cnt=%04h, expected 0/00/0000",
               stall, busy_mask, stall_cnt);
    end
    @(negedge clk);
    #2;
    set_idle();
    rst = 1'b1;
    exp_cnt = 16'h0;
    drain();
  endtask

  task automatic test_stats_saturation();
`ifdef ID_HAZARD_STATS_EN
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 16'hFFFD;
`endif
    for (int k = 0; k < 2; k++) begin
      cyc(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 0, 0, 8'h00, "sat_writer");
      cyc(1, 3'd7, 1, 3'd0, 0, 3'd0, 0, 0, 1, 8'h80, "sat_s1");
      cyc(1, 3'd7, 1, 3'd0, 0, 3'd0, 0, 0, 1, 8'h80, "sat_s2");
      cyc(1, 3'd7, 1, 3'd0, 0, 3'd0, 0, 0, 0, 8'h00, "sat_go");
      drain();
      check_cnt(k == 0 ? "stall_cnt_reaches_ffff" : "stall_cnt_holds_ffff");
    end
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    test_reset();
    test_raw_back_to_back();
    test_no_write();
    test_rd_en();
    test_distance();
    test_self_dep();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_stats_saturation();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations never compared", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_hazard_scoreboard
